rs_issue_arbiter: RTL and testbench
===================================

Name: rs_issue_arbiter

Overview:
Issue scheduler for one shared functional unit (ALU or MEM) fed by NUM_RS reservation-station entries. Each cycle it picks one ready entry round-robin, pulses that entry's clear line so the RS frees it, and holds the packet in a one-deep output register. The register drives the FU with a valid/ready handshake. Sits between the RS array and the execute stage, replacing the unconditional per-cycle issue path.

Parameters:
NUM_RS, 4, number of RS entries competing for the FU (power of 2, >=2)
IDX_W, $clog2(NUM_RS), width of entry index
PAYLOAD_W, 160, width of opaque issue packet (RS_EX_PACKET bits)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
rs_ready  in  NUM_RS  entry i is busy, operands valid, targets this FU
rs_payload  in  NUM_RS*PAYLOAD_W  packet of entry i at bits [i*PAYLOAD_W +: PAYLOAD_W]
squash  in  1  pipeline flush (mispredict)
fu_ready  in  1  FU accepts the packet this cycle
issue_valid  out  1  output register holds a packet
issue_payload  out  PAYLOAD_W  packet to FU
issue_idx  out  IDX_W  source entry of held packet
rs_clear  out  NUM_RS  one-hot, combinational; entry captured this cycle, RS clears busy at the edge

Behaviour:
- Reset (reset=0, async): issue_valid=0, issue_payload=0, issue_idx=0, rr_ptr=0. rs_clear is forced to 0 while reset is low.
- take = |rs_ready && !squash && (!issue_valid || fu_ready).
- grant = first i with rs_ready[i], searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_RS.
- rs_clear = take ? onehot(grant) : 0. At most one bit is set.
- On take, at the edge: issue_payload<=rs_payload[grant], issue_idx<=grant, issue_valid<=1, rr_ptr<=(grant+1) mod NUM_RS. The wrap from NUM_RS-1 to 0 uses natural IDX_W overflow.
- Latency: entry ready in cycle N produces rs_clear in cycle N and issue_valid in cycle N+1.
- Handshake: transfer occurs when issue_valid && fu_ready.
  - With transfer and no take: issue_valid<=0.
  - With transfer and take: back-to-back, register reloads, one issue per cycle sustained.
- Backpressure: while issue_valid && !fu_ready, issue_payload and issue_idx are held stable and rs_clear=0.
- Squash has priority over everything: issue_valid<=0, no capture, rs_clear=0, rr_ptr unchanged. A packet accepted by the FU in the squash cycle is still counted as transferred.
- No rs_ready: no capture, rr_ptr unchanged.
- Two states implied by issue_valid: EMPTY (0) and FULL (1).
  - EMPTY->FULL on take.
  - FULL->EMPTY on transfer without take, or on squash.
  - FULL->FULL on transfer with take, or on stall.

Optional Feature:
Macro ISSUE_PERF_EN. When defined, the block adds:
- output perf_issue_cnt [31:0]: increments on each transfer.
- output perf_stall_cnt [31:0]: increments on each cycle with issue_valid && !fu_ready.
- Both counters reset to 0, saturate at 32'hFFFFFFFF, and are not cleared by squash.

When undefined, neither the ports nor the counter logic exist.

Decomposition:
- Shared package: NUM_RS, ISSUE_PKT typedef (alias of RS_EX_PACKET), FUNC_UNIT enum. FUNC_UNIT is used by the RS to build rs_ready per unit.
- Sub-module rr_picker: combinational. Inputs req[NUM_RS] and ptr[IDX_W]; outputs gnt_onehot, gnt_idx and any. Implemented by rotate, priority-encode, then un-rotate. Reusable for CDB arbitration.

Test Plan:
- Reset mid-stream: issue_valid=1, reset driven low between edges -> issue_valid=0 immediately, rs_clear=0, and after release the first grant with rs_ready=4'b1111 is idx 0.
- Priority with pointer: rr_ptr=0, rs_ready=4'b1010, fu_ready=1 -> rs_clear=4'b0010 the same cycle, next cycle issue_valid=1, issue_idx=1. Then rs_ready=4'b1000 -> rs_clear=4'b1000, issue_idx=3.
- Fairness/wrap: rs_ready=4'b1111 constant, fu_ready=1 -> issue_idx sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one rs_clear bit set each cycle.
- Backpressure: packet held with fu_ready=0 for 3 cycles, rs_ready=4'b1111 -> issue_payload and issue_idx constant, rs_clear=0. Raising fu_ready=1 gives transfer and reload in the same cycle, next issue_idx=previous+1.
- Squash: issue_valid=1, rs_ready=4'b0001, squash=1 for one cycle -> rs_clear=0 in that cycle, issue_valid=0 next, rr_ptr unchanged. The following cycle grants idx 0.
- ISSUE_PERF_EN: 5 transfers with 2 stall cycles interleaved -> perf_issue_cnt=5, perf_stall_cnt=2. Preloaded at 32'hFFFFFFFF, a further transfer leaves it at 32'hFFFFFFFF.

Source files
------------

// File: rtl/rs_issue_arbiter_pkg.sv
// Shared types and defaults for the reservation-station issue path.
// Optional feature macro ISSUE_PERF_EN (see rs_issue_arbiter.sv).
package rs_issue_arbiter_pkg;

    localparam int NUM_RS         = 4;
    localparam int RS_EX_PACKET_W = 160;

    typedef logic [RS_EX_PACKET_W-1:0] rs_ex_packet_t;
    typedef rs_ex_packet_t             issue_pkt_t;

    // The RS uses this to decide which unit's rs_ready vector an entry feeds.
    typedef enum logic [0:0] {
        FU_ALU = 1'b0,
        FU_MEM = 1'b1
    } func_unit_e;

    // Occupancy of the one-deep output register.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

endpackage

// File: rtl/rs_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so that ptr sits at
// bit 0, take the lowest set bit, then rotate the index back. N must be a
// power of two so that index arithmetic wraps naturally.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] rot_idx;

    for (genvar g = 0; g < N; g++) begin : g_rot
        assign req_rot[g] = req[IDX_W'(g) + ptr];
    end

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = IDX_W'(i);
            end
        end
    end

    assign any     = |req;
    assign gnt_idx = rot_idx + ptr;

    // One-hot form of the un-rotated grant, empty when nobody requests.
    always_comb begin
        gnt_onehot = '0;
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Issue scheduler for one shared functional unit. Picks one ready RS entry
// per cycle round-robin, clears it in the RS, and holds the packet in a
// one-deep valid/ready output register.
// Optional feature: define ISSUE_PERF_EN to add saturating transfer and
// stall counters (perf_issue_cnt, perf_stall_cnt).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | output register free; any ready entry is captured
// ST_FULL  | packet presented to FU; reload only when FU accepts it
module rs_issue_arbiter #(
    parameter int NUM_RS    = rs_issue_arbiter_pkg::NUM_RS,
    parameter int IDX_W     = $clog2(NUM_RS),
    parameter int PAYLOAD_W = rs_issue_arbiter_pkg::RS_EX_PACKET_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_RS-1:0]           rs_ready,
    input  logic [NUM_RS*PAYLOAD_W-1:0] rs_payload,
    input  logic                        squash,
    input  logic                        fu_ready,
    output logic                        issue_valid,
    output logic [PAYLOAD_W-1:0]        issue_payload,
    output logic [IDX_W-1:0]            issue_idx,
    output logic [NUM_RS-1:0]           rs_clear
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]                 perf_issue_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    import rs_issue_arbiter_pkg::*;

    issue_state_e         state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_RS-1:0]    pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 take;
    logic [PAYLOAD_W-1:0] payload_arr [NUM_RS];

    for (genvar g = 0; g < NUM_RS; g++) begin : g_unpack
        assign payload_arr[g] = rs_payload[g*PAYLOAD_W +: PAYLOAD_W];
    end

    rr_picker #(
        .N     (NUM_RS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (rs_ready),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Capture is allowed when the register is free or being drained this cycle.
    assign take = pick_any && !squash && (!issue_valid || fu_ready);

    // The RS frees the entry at the same edge we capture it; silent in reset.
    assign rs_clear = (take && reset) ? pick_onehot : '0;

    // Output register FSM: squash empties, take (re)loads, lone transfer drains.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_EMPTY;
            issue_valid   <= 1'b0;
            issue_payload <= '0;
            issue_idx     <= '0;
            rr_ptr        <= '0;
        end else if (squash) begin
            state       <= ST_EMPTY;
            issue_valid <= 1'b0;
        end else if (take) begin
            state         <= ST_FULL;
            issue_valid   <= 1'b1;
            issue_payload <= payload_arr[pick_idx];
            issue_idx     <= pick_idx;
            rr_ptr        <= IDX_W'(pick_idx + 1'b1);
        end else begin
            case (state)
                ST_FULL: begin
                    if (fu_ready) begin
                        state       <= ST_EMPTY;
                        issue_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_EN
    // Saturating counters; a transfer during squash still counts, squash never clears.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue_valid && fu_ready && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (issue_valid && !fu_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_rs_issue_arbiter.sv
module tb_rs_issue_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int PW = 160;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    rs_ready = '0;
    logic [N*PW-1:0] rs_payload;
    logic            squash = 1'b0;
    logic            fu_ready = 1'b0;
    logic            issue_valid;
    logic [PW-1:0]   issue_payload;
    logic [IW-1:0]   issue_idx;
    logic [N-1:0]    rs_clear;
`ifdef ISSUE_PERF_EN
    logic [31:0]     perf_issue_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    logic [PW-1:0]   pl [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_valid;
    int            m_idx;
    int            m_ptr;
    logic [PW-1:0] m_pl;
    longint        m_ic;
    longint        m_sc;

    rs_issue_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .rs_ready      (rs_ready),
        .rs_payload    (rs_payload),
        .squash        (squash),
        .fu_ready      (fu_ready),
        .issue_valid   (issue_valid),
        .issue_payload (issue_payload),
        .issue_idx     (issue_idx),
        .rs_clear      (rs_clear)
`ifdef ISSUE_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    always_comb begin
        rs_payload = '0;
        for (int i = 0; i < N; i++) rs_payload[i*PW +: PW] = pl[i];
    end

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant_of(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_take();
        return (grant_of(rs_ready, m_ptr) >= 0) && !squash && (!m_valid || fu_ready);
    endfunction

    function automatic logic [N-1:0] model_clear();
        logic [N-1:0] c;
        c = '0;
        if (reset && model_take()) c[grant_of(rs_ready, m_ptr)] = 1'b1;
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_pl = '0; m_ic = 0; m_sc = 0;
    endtask

    task automatic model_edge();
        int g;
        bit tk;
        if (!reset) begin
            model_reset();
            return;
        end
        g  = grant_of(rs_ready, m_ptr);
        tk = model_take();
        if (m_valid && fu_ready  && m_ic < 64'hFFFF_FFFF) m_ic++;
        if (m_valid && !fu_ready && m_sc < 64'hFFFF_FFFF) m_sc++;
        if (squash) begin
            m_valid = 0;
        end else if (tk) begin
            m_valid = 1; m_idx = g; m_pl = pl[g]; m_ptr = (g + 1) % N;
        end else if (m_valid && fu_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic rand_payloads();
        for (int i = 0; i < N; i++) pl[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Inputs are set at edge+1; combinational check at edge+2, registers at next edge+1.
    task automatic do_cycle();
        #1;
        chk("rs_clear", PW'(rs_clear), PW'(model_clear()));
        @(posedge clock);
        model_edge();
        #1;
        chk("issue_valid", PW'(issue_valid), PW'(m_valid));
        chk("issue_idx", PW'(issue_idx), PW'(m_idx));
        chk("issue_payload", issue_payload, m_pl);
    endtask

    typedef struct {
        logic [N-1:0]  rdy;
        logic          sq;
        logic          fu;
        logic [N-1:0]  clr;
        logic          v;
        logic [IW-1:0] idx;
    } vec_t;

    vec_t tbl [15];

`ifdef ISSUE_PERF_EN
    logic [31:0] base_ic, base_sc;
    logic        seq_fu [8];
`endif

    initial begin
        tbl[0]  = '{4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[1]  = '{4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[12] = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[14] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};

        model_reset();
        rand_payloads();
        rs_ready = 4'b1111;
        fu_ready = 1'b1;

        // Reset state, including rs_clear forced low while reset is asserted
        #3;
        chk("reset_valid", PW'(issue_valid), PW'(0));
        chk("reset_idx", PW'(issue_idx), PW'(0));
        chk("reset_payload", issue_payload, '0);
        chk("reset_clear", PW'(rs_clear), PW'(0));
        @(posedge clock); #1;
        chk("reset_valid_edge", PW'(issue_valid), PW'(0));
        reset    = 1'b1;
        rs_ready = '0;

        // Directed table from a fresh reset (rr_ptr = 0)
        for (int r = 0; r < 15; r++) begin
            logic [PW-1:0] cap;
            rand_payloads();
            rs_ready = tbl[r].rdy;
            squash   = tbl[r].sq;
            fu_ready = tbl[r].fu;
            cap      = pl[tbl[r].idx];
            #1;
            chk($sformatf("tbl%0d_clear", r), PW'(rs_clear), PW'(tbl[r].clr));
            @(posedge clock);
            model_edge();
            #1;
            chk($sformatf("tbl%0d_valid", r), PW'(issue_valid), PW'(tbl[r].v));
            chk($sformatf("tbl%0d_idx", r), PW'(issue_idx), PW'(tbl[r].idx));
            if (tbl[r].clr != '0)
                chk($sformatf("tbl%0d_payload", r), issue_payload, cap);
            chk($sformatf("tbl%0d_payload_model", r), issue_payload, m_pl);
        end

        // Reset mid-stream: register is full, reset dropped between edges
        rs_ready = 4'b1111;
        squash   = 1'b0;
        fu_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", PW'(issue_valid), PW'(0));
        chk("midrst_clear", PW'(rs_clear), PW'(0));
        chk("midrst_payload", issue_payload, '0);
        #1;
        reset    = 1'b1;
        fu_ready = 1'b1;
        #1;
        chk("postrst_clear", PW'(rs_clear), PW'(4'b0001));
        @(posedge clock);
        model_edge();
        #1;
        chk("postrst_valid", PW'(issue_valid), PW'(1));
        chk("postrst_idx", PW'(issue_idx), PW'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rand_payloads();
            rs_ready = N'($urandom);
            squash   = ($urandom_range(0, 15) == 0);
            fu_ready = ($urandom_range(0, 3) != 0);
            do_cycle();
        end

`ifdef ISSUE_PERF_EN
        // 5 transfers with 2 stalls interleaved
        rs_ready = '0; squash = 1'b1; fu_ready = 1'b1;
        do_cycle();
        squash = 1'b0;
        base_ic = perf_issue_cnt;
        base_sc = perf_stall_cnt;
        seq_fu = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 8; s++) begin
            rand_payloads();
            rs_ready = 4'b1111;
            fu_ready = seq_fu[s];
            do_cycle();
        end
        chk("perf_issue_delta", PW'(perf_issue_cnt - base_ic), PW'(5));
        chk("perf_stall_delta", PW'(perf_stall_cnt - base_sc), PW'(2));
        chk("perf_issue_model", PW'(perf_issue_cnt), PW'(m_ic));
        chk("perf_stall_model", PW'(perf_stall_cnt), PW'(m_sc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
